// File: rtl/ntru_pkg.sv
// Shared NTRU datapath definitions: polynomial length, 2-bit ternary
// coefficient encoding {sign, nonzero} and the sampler FSM states.
package ntru_pkg;

    localparam int unsigned N = 701;

    typedef logic [1:0] ter_t;

    localparam ter_t TER_ZERO = 2'b00;
    localparam ter_t TER_POS  = 2'b01;
    localparam ter_t TER_NEG  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } sample_state_t;

endpackage

// File: rtl/mod3_ter.sv
// Combinational byte -> ternary coefficient, value mod 3.
// Ports:
//   value : 8-bit unsigned input byte
//   ter   : ternary encoding of (value mod 3): 0 -> 00, 1 -> 01, 2 -> 11
module mod3_ter
    import ntru_pkg::*;
(
    input  logic [7:0] value,
    output ter_t       ter
);

    // 4 = 1 (mod 3), so the sum of the base-4 digits keeps the residue.
    logic [3:0] digit_sum;

    always_comb begin
        digit_sum = 4'(value[1:0]) + 4'(value[3:2])
                  + 4'(value[5:4]) + 4'(value[7:6]);
        case (digit_sum)
            4'd0, 4'd3, 4'd6, 4'd9, 4'd12: ter = TER_ZERO;
            4'd1, 4'd4, 4'd7, 4'd10:       ter = TER_POS;
            default:                       ter = TER_NEG;  // 2, 5, 8, 11
        endcase
    end

endmodule

// File: rtl/sample_iid_ter.sv
// Samples a ternary polynomial from a stream of uniform random bytes.
// Each accepted byte becomes one coefficient (byte mod 3); coefficients
// 0..N-2 are filled in order, coefficient N-1 stays zero.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : request a new polynomial (honoured in IDLE only)
//   rnd_byte   : random byte, qualified by rnd_valid
//   rnd_valid  : rnd_byte valid
//   rnd_ready  : byte accepted this cycle when rnd_valid is high
//   busy       : sampling in progress
//   done       : one-cycle pulse, poly is complete
//   poly       : packed polynomial, coefficient i at poly[2i+2:2i+1]
module sample_iid_ter
    import ntru_pkg::*;
#(
    parameter int unsigned N      = ntru_pkg::N,
    parameter int unsigned BYTE_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [BYTE_W-1:0] rnd_byte,
    input  logic              rnd_valid,
    output logic              rnd_ready,
    output logic              busy,
    output logic              done,
    output logic [2*N:1]      poly
);

    localparam int unsigned      IDX_W    = $clog2(N - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 2);

    sample_state_t    state;
    logic [IDX_W-1:0] idx;
    ter_t             coeff;

    mod3_ter u_mod3 (
        .value (rnd_byte[7:0]),
        .ter   (coeff)
    );

    // Sampler FSM; rnd_ready/busy/done are registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            poly      <= '0;
            rnd_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= RUN;
                        idx       <= '0;
                        poly      <= '0;
                        rnd_ready <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (rnd_valid && rnd_ready) begin
                        poly[2*int'(idx)+1 +: 2] <= coeff;
                        // idx stops at N-2; the top coefficient is never written.
                        if (idx == LAST_IDX) begin
                            state     <= DONE;
                            rnd_ready <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            idx <= idx + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    rnd_ready <= 1'b0;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_iid_ter.sv
// Directed self-checking bench for sample_iid_ter and mod3_ter.
module tb_sample_iid_ter;
    import ntru_pkg::*;

    localparam int unsigned TN = 701;
    localparam int unsigned PW = 2 * TN;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [7:0]    rnd_byte;
    logic          rnd_valid;
    logic          rnd_ready;
    logic          busy;
    logic          done;
    logic [PW:1]   poly;
    logic [7:0]    m_in;
    ter_t          m_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sample_iid_ter #(.N(TN), .BYTE_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .rnd_byte  (rnd_byte),
        .rnd_valid (rnd_valid),
        .rnd_ready (rnd_ready),
        .busy      (busy),
        .done      (done),
        .poly      (poly)
    );

    mod3_ter u_m3 (
        .value (m_in),
        .ter   (m_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_poly(input string tag, input logic [PW:1] exp);
        int bad;
        bad = 0;
        for (int i = int'(TN) - 1; i >= 0; i--)
            if (poly[2*i+1 +: 2] !== exp[2*i+1 +: 2]) bad = i;
        checks++;
        assert (poly === exp) else begin
            failures++;
            $error("FAIL %s first_bad_coeff=%0d observed=%b expected=%b",
                   tag, bad, poly[2*bad+1 +: 2], exp[2*bad+1 +: 2]);
        end
    endtask

    function automatic logic [7:0] byte_of(input int kind, input int i);
        case (kind)
            0:       return 8'h00;
            1:       return 8'(i % 256);
            2:       return 8'hFE;
            default: return 8'h01;
        endcase
    endfunction

    function automatic ter_t ref_ter(input logic [7:0] b);
        case (int'(b) % 3)
            0:       return 2'b00;
            1:       return 2'b01;
            default: return 2'b11;
        endcase
    endfunction

    function automatic logic [PW:1] exp_poly(input int kind);
        logic [PW:1] p;
        p = '0;
        for (int i = 0; i < int'(TN) - 1; i++) p[2*i+1 +: 2] = ref_ter(byte_of(kind, i));
        return p;
    endfunction

    // One polynomial: start, feed bytes, check latency/handshake/result.
    // abort_at >= 0 asserts rst once that many bytes have been accepted.
    task automatic run_poly(input string tag, input int kind, input bit toggle,
                            input bit disturb, input int abort_at);
        int cyc, acc, lows, bad;
        bit hs, got_done;
        @(negedge clk);
        start     = 1'b1;
        rnd_valid = 1'b0;
        @(negedge clk);
        start = 1'b0;
        cyc = 1; acc = 0; lows = 0; bad = 0; got_done = 0;
        chk({tag, "_busy_t1"}, 32'(busy), 1);
        chk({tag, "_ready_t1"}, 32'(rnd_ready), 1);
        chk_poly({tag, "_clear_t1"}, '0);
        while (cyc < 4000) begin
            if (done === 1'b1) begin
                got_done = 1;
                break;
            end
            if (abort_at >= 0 && acc == abort_at) break;
            if (rnd_ready !== 1'b1 || busy !== 1'b1) bad++;
            rnd_valid = toggle ? ((cyc % 2) == 1) : 1'b1;
            rnd_byte  = rnd_valid ? byte_of(kind, acc) : 8'h00;
            if (!rnd_valid) lows++;
            if (disturb) start = ($urandom_range(0, 3) == 0);
            hs = rnd_valid;
            @(negedge clk);
            if (hs) acc++;
            cyc++;
        end
        start     = 1'b0;
        rnd_valid = 1'b0;
        chk({tag, "_run_ready_busy_bad"}, 32'(bad), 0);
        if (abort_at >= 0) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk({tag, "_rst_done"}, 32'(done), 0);
            chk({tag, "_rst_busy"}, 32'(busy), 0);
            chk({tag, "_rst_ready"}, 32'(rnd_ready), 0);
            chk_poly({tag, "_rst_poly"}, '0);
            return;
        end
        chk({tag, "_done_seen"}, 32'(got_done), 1);
        // Minimum N cycles, plus one per valid-low cycle in RUN.
        chk({tag, "_latency"}, 32'(cyc), 32'(TN + lows));
        chk({tag, "_accepted"}, 32'(acc), 32'(TN - 1));
        chk({tag, "_done_busy"}, 32'(busy), 0);
        chk({tag, "_done_ready"}, 32'(rnd_ready), 0);
        chk_poly({tag, "_final"}, exp_poly(kind));
        if (disturb) start = 1'b1;  // must be ignored in the done cycle
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_done_pulse_end"}, 32'(done), 0);
        chk({tag, "_idle_busy"}, 32'(busy), 0);
        @(negedge clk);
        chk({tag, "_no_restart"}, 32'(busy), 0);
        chk_poly({tag, "_hold"}, exp_poly(kind));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rnd_valid = 1'b0; rnd_byte = 8'h00; m_in = 8'h00;
        repeat (2) @(negedge clk);
        chk("reset_done", 32'(done), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ready", 32'(rnd_ready), 0);
        chk_poly("reset_poly", '0);
        rst = 1'b0;

        // Bytes offered in IDLE are not consumed and do not start anything.
        rnd_valid = 1'b1; rnd_byte = 8'h55;
        repeat (3) @(negedge clk);
        chk("idle_ready", 32'(rnd_ready), 0);
        chk("idle_busy", 32'(busy), 0);
        chk_poly("idle_poly", '0);
        rnd_valid = 1'b0;

        run_poly("zero", 0, 1'b0, 1'b0, -1);

        run_poly("ramp", 1, 1'b0, 1'b0, -1);
        chk("ramp_c1", 32'(poly[4:3]), 32'h1);
        chk("ramp_c2", 32'(poly[6:5]), 32'h3);
        chk("ramp_c255", 32'(poly[512:511]), 32'h0);
        chk("ramp_c700", 32'(poly[1402:1401]), 32'h0);

        run_poly("fe_toggle", 2, 1'b1, 1'b0, -1);
        run_poly("ramp_disturb", 1, 1'b0, 1'b1, -1);
        run_poly("abort", 1, 1'b0, 1'b0, 350);
        run_poly("ones", 3, 1'b0, 1'b0, -1);
        chk("ones_c0", 32'(poly[2:1]), 32'h1);
        chk("ones_c700", 32'(poly[1402:1401]), 32'h0);

        for (int v = 0; v < 256; v++) begin
            m_in = 8'(v);
            #1;
            chk($sformatf("mod3_%0d", v), 32'(m_out), 32'(ref_ter(8'(v))));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
